// File: rtl/ntsc_zbt_writer_if.sv
// NTSC packer / display / ZBT port bundle for ntsc_zbt_writer.
// The slave modport is the writer itself; the master modport is its environment.
interface ntsc_zbt_writer_if;
  logic        ntsc_we;
  logic [18:0] ntsc_addr;
  logic [35:0] ntsc_data;
  logic        frame_number;
  logic        disp_req;
  logic [18:0] disp_addr;
  logic [18:0] zbt_addr;
  logic        zbt_we;
  logic [35:0] zbt_wdata;
  logic        fifo_full;
  logic [7:0]  overflow_cnt;
  logic        disp_buf;

  modport slave (
    input  ntsc_we, ntsc_addr, ntsc_data, frame_number,
    input  disp_req, disp_addr,
    output zbt_addr, zbt_we, zbt_wdata,
    output fifo_full, overflow_cnt, disp_buf
  );

  modport master (
    output ntsc_we, ntsc_addr, ntsc_data, frame_number,
    output disp_req, disp_addr,
    input  zbt_addr, zbt_we, zbt_wdata,
    input  fifo_full, overflow_cnt, disp_buf
  );
endinterface

// File: rtl/ntsc_zbt_writer.sv
// NTSC-to-ZBT write FIFO with display-priority arbitration.
// Optional DOUBLE_BUFFER_EN selects the frame half via address bit 18.
module ntsc_zbt_writer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  ntsc_zbt_writer_if.slave   bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic        frame;
    logic [18:0] addr;
    logic [35:0] data;
  } entry_t;

  entry_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      ovf_q, ovf_d;
  logic [18:0]     zbt_addr_q, zbt_addr_d;
  logic            zbt_we_q, zbt_we_d;
  logic [35:0]     wdata_q, wdata_d;
  logic            p1_v_q, p1_v_d;
  logic [35:0]     p1_data_q, p1_data_d;
  logic            p2_v_q, p2_v_d;
  logic [35:0]     p2_data_q, p2_data_d;
  logic            disp_buf_q, disp_buf_d;

  entry_t          head;
  entry_t          wr_entry;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;
  logic            drop;
  logic [18:0]     wr_addr;
  logic [18:0]     rd_addr;
  logic            unused_bits;

  always_comb begin
    head     = mem_q[rd_ptr_q];
    wr_entry = '{frame: bus.frame_number,
                 addr:  bus.ntsc_addr,
                 data:  bus.ntsc_data};
    full  = (count_q == CW'(FIFO_DEPTH));
    empty = (count_q == '0);
    pop   = !bus.disp_req && !empty;
    push  = bus.ntsc_we && (!full || pop);
    drop  = bus.ntsc_we && full && !pop;
  end

`ifdef DOUBLE_BUFFER_EN
  always_comb begin
    wr_addr     = {head.frame, head.addr[17:0]};
    rd_addr     = {disp_buf_q, bus.disp_addr[17:0]};
    disp_buf_d  = ~bus.frame_number;
    unused_bits = ^{head.addr[18], bus.disp_addr[18]};
  end
`else
  always_comb begin
    wr_addr     = head.addr;
    rd_addr     = bus.disp_addr;
    disp_buf_d  = 1'b0;
    unused_bits = head.frame;
  end
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    ovf_d      = ovf_q;
    zbt_addr_d = zbt_addr_q;
    zbt_we_d   = 1'b0;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (drop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    unique case (1'b1)
      bus.disp_req: zbt_addr_d = rd_addr;
      pop: begin
        zbt_addr_d = wr_addr;
        zbt_we_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Write data trails its address by two edges to match the ZBT pipeline
  always_comb begin
    p1_v_d    = pop;
    p1_data_d = pop ? head.data : p1_data_q;
    p2_v_d    = p1_v_q;
    p2_data_d = p1_data_q;
    wdata_d   = p2_v_q ? p2_data_q : wdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= '0;
      zbt_addr_q <= '0;
      zbt_we_q   <= 1'b0;
      wdata_q    <= '0;
      p1_v_q     <= 1'b0;
      p1_data_q  <= '0;
      p2_v_q     <= 1'b0;
      p2_data_q  <= '0;
      disp_buf_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      zbt_addr_q <= zbt_addr_d;
      zbt_we_q   <= zbt_we_d;
      wdata_q    <= wdata_d;
      p1_v_q     <= p1_v_d;
      p1_data_q  <= p1_data_d;
      p2_v_q     <= p2_v_d;
      p2_data_q  <= p2_data_d;
      disp_buf_q <= disp_buf_d;
    end
  end

  assign bus.zbt_addr     = zbt_addr_q;
  assign bus.zbt_we       = zbt_we_q;
  assign bus.zbt_wdata    = wdata_q;
  assign bus.fifo_full    = full;
  assign bus.overflow_cnt = ovf_q;
  assign bus.disp_buf     = disp_buf_q;

endmodule

// File: tb/tb_ntsc_zbt_writer.sv
// Scoreboard bench for ntsc_zbt_writer (default and DOUBLE_BUFFER_EN builds).
module tb_ntsc_zbt_writer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ntsc_zbt_writer_if bus ();

  ntsc_zbt_writer #(.FIFO_DEPTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [18:0] addr;
    logic [35:0] data;
  } wr_t;

  typedef struct {
    int          due;
    logic [35:0] data;
  } wd_t;

  wr_t exp_q[$];
  wd_t wd_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;

  function automatic logic [18:0] exp_waddr(input logic f,
                                            input logic [18:0] a);
`ifdef DOUBLE_BUFFER_EN
    return {f, a[17:0]};
`else
    return a;
`endif
  endfunction

  function automatic logic [35:0] rnd36();
    return {4'($urandom_range(0, 15)), 32'($urandom)};
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: address checked when zbt_we shows, data two edges later
  always @(negedge clk) begin
    wr_t e;
    wd_t w;
    if (reset_n) begin
      if (wd_q.size() > 0 && wd_q[0].due == cyc) begin
        w = wd_q.pop_front();
        n_cmp++;
        if (bus.zbt_wdata !== w.data) begin
          n_err++;
          $display("FAIL sb_wdata: got %h want %h", bus.zbt_wdata, w.data);
        end
      end
      if (bus.zbt_we === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected_write: addr %h", bus.zbt_addr);
        end else begin
          e = exp_q.pop_front();
          if (bus.zbt_addr !== e.addr) begin
            n_err++;
            $display("FAIL sb_addr: got %h want %h", bus.zbt_addr, e.addr);
          end
          wd_q.push_back('{cyc + 2, e.data});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [18:0] a, input logic [35:0] d,
                           input bit acc);
    bus.ntsc_we   = 1'b1;
    bus.ntsc_addr = a;
    bus.ntsc_data = d;
    if (acc) exp_q.push_back('{exp_waddr(bus.frame_number, a), d});
    step();
    bus.ntsc_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || wd_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || wd_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: pending %0d/%0d want 0/0",
               exp_q.size(), wd_q.size());
    end
  endtask

  task automatic test_reset();
    step();
    step();
    n_cmp += 6;
    if (bus.zbt_addr !== 19'h0) begin
      n_err++; $display("FAIL rst_addr: got %h want 0", bus.zbt_addr);
    end
    if (bus.zbt_we !== 1'b0) begin
      n_err++; $display("FAIL rst_we: got %b want 0", bus.zbt_we);
    end
    if (bus.zbt_wdata !== 36'h0) begin
      n_err++; $display("FAIL rst_wdata: got %h want 0", bus.zbt_wdata);
    end
    if (bus.fifo_full !== 1'b0) begin
      n_err++; $display("FAIL rst_full: got %b want 0", bus.fifo_full);
    end
    if (bus.overflow_cnt !== 8'h0) begin
      n_err++; $display("FAIL rst_ovf: got %h want 0", bus.overflow_cnt);
    end
    if (bus.disp_buf !== 1'b0) begin
      n_err++; $display("FAIL rst_disp_buf: got %b want 0", bus.disp_buf);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_write();
    push_word(19'h00123, 36'h0DEADBEEF, 1'b1);
    n_cmp++;
    if (bus.zbt_we !== 1'b0) begin
      n_err++; $display("FAIL sw_we_early: got %b want 0", bus.zbt_we);
    end
    step();
    n_cmp += 2;
    if (bus.zbt_we !== 1'b1) begin
      n_err++; $display("FAIL sw_we: got %b want 1", bus.zbt_we);
    end
    if (bus.zbt_addr !== 19'h00123) begin
      n_err++; $display("FAIL sw_addr: got %h want 00123", bus.zbt_addr);
    end
    step();
    step();
    n_cmp++;
    if (bus.zbt_wdata !== 36'h0DEADBEEF) begin
      n_err++;
      $display("FAIL sw_wdata: got %h want 0deadbeef", bus.zbt_wdata);
    end
    drain();
  endtask

  task automatic test_priority();
    bus.disp_req  = 1'b1;
    bus.disp_addr = 19'h7FFFF;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) push_word(19'h00200 + 19'(i), rnd36(), 1'b1);
      else step();
      n_cmp++;
      if (bus.zbt_we !== 1'b0 || bus.zbt_addr !== 19'h7FFFF) begin
        n_err++;
        $display("FAIL prio_read%0d: got we=%b addr=%h want we=0 addr=7ffff",
                 i, bus.zbt_we, bus.zbt_addr);
      end
    end
    bus.disp_req = 1'b0;
    drain();
  endtask

  task automatic test_overflow();
    bus.disp_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_word(19'h00300 + 19'(i), rnd36(), i < 8);
      if (i == 6 || i == 7) begin
        n_cmp++;
        if (bus.fifo_full !== (i == 7)) begin
          n_err++;
          $display("FAIL ovf_full%0d: got %b want %b", i, bus.fifo_full,
                   i == 7);
        end
      end
    end
    n_cmp++;
    if (bus.overflow_cnt !== 8'd2) begin
      n_err++; $display("FAIL ovf_cnt2: got %0d want 2", bus.overflow_cnt);
    end
    bus.ntsc_we = 1'b1;
    for (int i = 0; i < 290; i++) step();
    bus.ntsc_we = 1'b0;
    n_cmp += 2;
    if (bus.overflow_cnt !== 8'd255) begin
      n_err++; $display("FAIL ovf_sat: got %0d want 255", bus.overflow_cnt);
    end
    if (bus.fifo_full !== 1'b1) begin
      n_err++; $display("FAIL ovf_still_full: got %b want 1", bus.fifo_full);
    end
    bus.disp_req = 1'b0;
    drain();
  endtask

  task automatic test_mid_reset();
    bus.disp_req = 1'b1;
    for (int i = 0; i < 4; i++) push_word(19'h00400 + 19'(i), rnd36(), 1'b1);
    bus.disp_req = 1'b0;
    step();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    wd_q.delete();
    #1;
    n_cmp++;
    if (bus.zbt_we !== 1'b0 || bus.zbt_addr !== 19'h0 ||
        bus.zbt_wdata !== 36'h0 || bus.fifo_full !== 1'b0 ||
        bus.overflow_cnt !== 8'h0 || bus.disp_buf !== 1'b0) begin
      n_err++;
      $display("FAIL mr_zero: got we=%b a=%h d=%h f=%b o=%h b=%b want all 0",
               bus.zbt_we, bus.zbt_addr, bus.zbt_wdata, bus.fifo_full,
               bus.overflow_cnt, bus.disp_buf);
    end
    bus.ntsc_we = 1'b1;
    step();
    bus.ntsc_we = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (bus.zbt_we !== 1'b0 || bus.zbt_wdata !== 36'h0) begin
        n_err++;
        $display("FAIL mr_quiet%0d: got we=%b d=%h want 0/0", i,
                 bus.zbt_we, bus.zbt_wdata);
      end
    end
  endtask

  task automatic test_push_while_full();
    bus.disp_req = 1'b1;
    for (int i = 0; i < 8; i++) push_word(19'h00500 + 19'(i), rnd36(), 1'b1);
    n_cmp++;
    if (bus.fifo_full !== 1'b1) begin
      n_err++; $display("FAIL pf_full: got %b want 1", bus.fifo_full);
    end
    bus.disp_req = 1'b0;
    push_word(19'h00777, 36'h777777777, 1'b1);
    n_cmp += 2;
    if (bus.fifo_full !== 1'b1) begin
      n_err++; $display("FAIL pf_occ: got %b want 1", bus.fifo_full);
    end
    if (bus.overflow_cnt !== 8'd0) begin
      n_err++; $display("FAIL pf_ovf: got %0d want 0", bus.overflow_cnt);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int occ = 0;
    logic pf = 1'b0;
    for (int i = 0; i < 60; i++) begin
      logic dr, we, f, pop, acc;
      logic [18:0] da, wa;
      dr = ($urandom_range(0, 3) == 0);
      we = (i < 6) ? 1'b1 : 1'($urandom_range(0, 1));
      f  = 1'($urandom_range(0, 1));
      da = 19'($urandom);
      wa = 19'($urandom);
      pop = !dr && occ > 0;
      acc = we && (occ < 8 || pop);
      occ = occ + int'(acc) - int'(pop);
      bus.disp_req     = dr;
      bus.disp_addr    = da;
      bus.frame_number = f;
      if (we) push_word(wa, rnd36(), acc);
      else step();
      if (dr) begin
        logic [18:0] ra;
`ifdef DOUBLE_BUFFER_EN
        ra = {~pf, da[17:0]};
`else
        ra = da;
`endif
        n_cmp++;
        if (bus.zbt_we !== 1'b0 || bus.zbt_addr !== ra) begin
          n_err++;
          $display("FAIL b2b_read%0d: got we=%b addr=%h want we=0 addr=%h",
                   i, bus.zbt_we, bus.zbt_addr, ra);
        end
      end
      pf = f;
    end
    bus.disp_req = 1'b0;
    bus.frame_number = 1'b0;
    drain();
  endtask

  task automatic test_frame_buffer();
    logic want_b;
    bus.frame_number = 1'b0;
    step();
`ifdef DOUBLE_BUFFER_EN
    want_b = 1'b1;
`else
    want_b = 1'b0;
`endif
    n_cmp++;
    if (bus.disp_buf !== want_b) begin
      n_err++;
      $display("FAIL fb_buf_f0: got %b want %b", bus.disp_buf, want_b);
    end
    bus.frame_number = 1'b1;
    push_word(19'h00010, 36'h123456789, 1'b1);
    n_cmp++;
    if (bus.disp_buf !== 1'b0) begin
      n_err++; $display("FAIL fb_buf_f1: got %b want 0", bus.disp_buf);
    end
    step();
    n_cmp++;
    if (bus.zbt_addr !== exp_waddr(1'b1, 19'h00010)) begin
      n_err++;
      $display("FAIL fb_addr: got %h want %h", bus.zbt_addr,
               exp_waddr(1'b1, 19'h00010));
    end
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: sim did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ntsc_we      = 1'b0;
    bus.ntsc_addr    = '0;
    bus.ntsc_data    = '0;
    bus.frame_number = 1'b0;
    bus.disp_req     = 1'b0;
    bus.disp_addr    = '0;
    test_reset();
    test_single_write();
    test_priority();
    test_overflow();
    test_mid_reset();
    test_push_while_full();
    test_back_to_back();
    test_frame_buffer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ntsc_zbt_writer.md
NTSC_ZBT_WRITER -- requirements
Module: ntsc_zbt_writer

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port ntsc_we  input  1  one-cycle strobe: new word on ntsc_addr/ntsc_data.
REQ-004 SHALL have port ntsc_addr  input  19  ZBT word address from the NTSC packer.
REQ-005 SHALL have port ntsc_data  input  36  packed pixel word from the NTSC packer.
REQ-006 SHALL have port frame_number  input  1  frame toggle from the NTSC packer.
REQ-007 SHALL have port disp_req  input  1  display read request this cycle.
REQ-008 SHALL have port disp_addr  input  19  display read address.
REQ-009 SHALL have port zbt_addr  output  19  registered ZBT address.
REQ-010 SHALL have port zbt_we  output  1  registered ZBT write enable, active high.
REQ-011 SHALL have port zbt_wdata  output  36  ZBT write data, two cycles after its address.
REQ-012 SHALL have port fifo_full  output  1  write FIFO holds 8 entries.
REQ-013 SHALL have port overflow_cnt  output  8  count of dropped writes, saturating.
REQ-014 SHALL have port disp_buf  output  1  buffer the display reads from.
REQ-015 SHALL have parameter FIFO_DEPTH, default 8, FIFO entries (power of two, 2..16).

Function
REQ-016 SHALL push {frame_number, ntsc_addr, ntsc_data} into the FIFO on every edge where ntsc_we=1 and the FIFO is not full.
REQ-017 SHALL accept a push when full if a pop happens in the same cycle; occupancy is then unchanged.
REQ-018 SHALL drop a push when full with no pop, and increment overflow_cnt, saturating at 255.
REQ-019 SHALL arbitrate each cycle: disp_req=1 -> read (zbt_we<=0, zbt_addr<=disp_addr); else FIFO non-empty -> pop (zbt_we<=1, zbt_addr<=entry address); else idle (zbt_we<=0, zbt_addr held).
REQ-020 SHALL give display reads strict priority; writes wait without limit while disp_req=1.
REQ-021 SHALL drive zbt_wdata with the popped data exactly two edges after the edge that drove its zbt_we=1; otherwise zbt_wdata holds its value.
REQ-022 SHALL have latency: ntsc_we sampled at edge k with FIFO empty and disp_req=0 at k+1 -> zbt_we=1 after edge k+1, zbt_wdata valid after edge k+3.
REQ-023 SHALL pop in FIFO order; pointers wrap modulo FIFO_DEPTH; fifo_full is combinational from occupancy==FIFO_DEPTH.
REQ-024 SHALL treat ntsc_we while reset_n=0 as ignored.

Reset
REQ-025 SHALL, on reset_n=0 at any time, immediately clear: zbt_addr=0, zbt_we=0, zbt_wdata=0, FIFO empty, fifo_full=0, overflow_cnt=0, disp_buf=0, write-data pipeline empty.
REQ-026 SHALL discard FIFO contents and in-flight write data when reset asserts mid-operation; no write completes after release without a new push.

Configuration
REQ-027 SHALL, with DOUBLE_BUFFER_EN defined, drive zbt_addr[18] on writes from the entry's stored frame_number (bits [17:0] from ntsc_addr); register disp_buf <= ~frame_number each cycle; and force disp_addr[18] to disp_buf on reads.
REQ-028 SHALL, without DOUBLE_BUFFER_EN, pass all 19 address bits unchanged and hold disp_buf at 0.

Verification
REQ-029 SHALL cover a single write: ntsc_we pulse with addr 0x00123, data 0x0DEADBEEF, disp_req=0 -> zbt_we=1 with zbt_addr=0x00123 one edge later, zbt_wdata=0x0DEADBEEF two edges after that.
REQ-030 SHALL cover priority: disp_req=1 with disp_addr 0x7FFFF for 5 cycles while 3 writes are queued -> 5 reads at 0x7FFFF, then 3 writes in order.
REQ-031 SHALL cover overflow: disp_req held 1 and 10 ntsc_we pulses -> fifo_full=1 after 8, overflow_cnt=2; 300 pulses -> overflow_cnt=255.
REQ-032 SHALL cover push while full: full FIFO, disp_req=0, and ntsc_we in the same cycle as a pop -> overflow_cnt unchanged and the new entry written last.
REQ-033 SHALL cover mid-operation reset: reset_n low for 1 cycle with 4 queued writes -> all outputs zero and no zbt_we until a new push.
REQ-034 SHALL cover DOUBLE_BUFFER_EN: write addr 0x00010 with frame_number=1 -> zbt_addr=0x40010, and disp_buf=0 one edge after frame_number=1.
